// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding
// and the checksum / word-counter widths.
package loader_pkg;

    localparam int CSUM_W = 32;
    // One bit wider than a word so that a full-capacity image count fits without overflow.
    localparam int CNT_W  = CSUM_W + 1;

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_SUM,
        S_RUN,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/uart_boot_loader.sv
// Boot sequencer: parses a length-prefixed, XOR-checksummed program image from the
// receiver word stream into instruction memory and releases the core once verified.
module uart_boot_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [31:0]       prog_words
);

    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic [CSUM_W-1:0] acc;
    logic [ADDR_W-1:0] addr;

    function automatic logic header_too_long(input logic [CSUM_W-1:0] n);
        return {1'b0, n} > CAPACITY;
    endfunction

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (accept) begin
                    if (header_too_long(in_data)) begin
                        state_nxt = S_ERR;
                    end else if (in_data == '0) begin
                        state_nxt = S_SUM;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept && cnt == CNT_W'(1)) begin
                    state_nxt = S_SUM;
                end
            end
            S_SUM: begin
                if (accept) begin
                    state_nxt = (in_data == acc) ? S_RUN : S_ERR;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Status and handshake outputs are decoded from state alone.
    always_comb begin
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_LEN, S_LOAD, S_SUM: in_ready = 1'b1;
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Stage p0 -> p1: header latch, payload write issue, checksum accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            prog_words <= '0;
            cnt        <= '0;
            acc        <= '0;
            addr       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN: begin
                        prog_words <= in_data;
                        cnt        <= {1'b0, in_data};
                        acc        <= in_data;
                        addr       <= '0;
                    end
                    S_LOAD: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= in_data;
                        acc        <= acc ^ in_data;
                        // Wraps to 0 after the last word of a full-capacity image; no write follows.
                        addr       <= addr + ADDR_W'(1);
                        cnt        <= cnt - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of images driven with random
// valid gaps against a stream-index reference model.
module tb_uart_boot_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [31:0]   prog_words;

    int checks = 0;
    int errors = 0;

    uart_boot_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .prog_words (prog_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit fixed;
        bit bad;
        int gap_pct;
        int abort_at;
        bit pre_reset;
        bit exp_done;
        bit exp_err;
        int exp_writes;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_prog_words"}, prog_words, 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_image(input vec_t v, input int id);
        logic [31:0] words[$];
        logic [31:0] sum;
        int          cons;
        bit          ok;
        int          idx;
        int          post;
        int          got_w;
        int          cyc;
        bit          pend;
        logic [31:0] pend_addr;
        logic [31:0] pend_data;
        bit          offer;
        bit          acc;
        bit          terminal;
        bit          aborted;

        if (v.pre_reset) do_reset();

        words.push_back(32'(v.n));
        sum = 32'(v.n);
        for (int i = 0; i < v.n; i++) begin
            logic [31:0] w;
            if (v.fixed && v.n == 3) w = 32'h1111_1111 << i;
            else w = $urandom;
            words.push_back(w);
            sum ^= w;
        end
        words.push_back(sum ^ 32'(v.bad));
        words.push_back($urandom);
        words.push_back($urandom);

        cons = (v.n > CAP) ? 1 : v.n + 2;
        ok   = (v.n <= CAP) && !v.bad;
        idx = 0; post = 0; got_w = 0; cyc = 0;
        pend = 1'b0; pend_addr = '0; pend_data = '0;
        aborted = 1'b0;

        while (1) begin
            @(negedge clk);
            terminal = (idx >= cons);
            chk("in_ready", 32'(in_ready), 32'(idx < cons));
            chk("imem_we", 32'(imem_we), 32'(pend));
            if (imem_we) got_w++;
            if (pend) begin
                chk("imem_addr", 32'(imem_addr), pend_addr);
                chk("imem_wdata", imem_wdata, pend_data);
            end
            chk("done", 32'(done), 32'(terminal && ok));
            chk("error", 32'(error), 32'(terminal && !ok));
            chk("cpu_rst", 32'(cpu_rst), 32'(!(terminal && ok)));
            chk("prog_words", prog_words, (idx >= 1) ? 32'(v.n) : 32'd0);
            if (terminal) begin
                post++;
                if (post >= 4) break;
            end
            cyc++;
            if (cyc > 1000) begin
                errors++;
                $display("FAIL timeout image %0d: idx %0d required %0d", id, idx, cons);
                break;
            end

            offer = (idx < words.size()) && ($urandom_range(0, 99) >= v.gap_pct);
            in_valid = offer;
            in_data  = offer ? words[idx] : $urandom;
            acc = offer && (idx < cons);

            @(posedge clk);
            pend      = acc && idx >= 1 && idx <= v.n;
            pend_addr = 32'((idx - 1) % CAP);
            pend_data = words[idx];
            if (acc) idx++;

            if (acc && v.abort_at >= 0 && idx == 1 + v.abort_at) begin
                #2;
                rst = 1'b1;
                in_valid = 1'b0;
                #1;
                chk_reset_values("abort");
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;

        chk("writes_total", 32'(got_w), 32'(v.exp_writes));
        chk("done_final", 32'(done), 32'(v.exp_done));
        chk("error_final", 32'(error), 32'(v.exp_err));
        if (!aborted) chk("cpu_rst_final", 32'(cpu_rst), 32'(!v.exp_done));
    endtask

    initial begin
        vec_t tbl[$];
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk_reset_values("power_on");
        @(negedge clk);
        rst = 1'b0;

        //        n   fixed bad gap abort pre  done err writes
        tbl.push_back('{3,  1, 0, 0,  -1, 1, 1, 0, 3});
        tbl.push_back('{3,  1, 1, 0,  -1, 1, 0, 1, 3});
        tbl.push_back('{0,  0, 0, 0,  -1, 1, 1, 0, 0});
        tbl.push_back('{0,  0, 1, 0,  -1, 1, 0, 1, 0});
        tbl.push_back('{17, 0, 0, 0,  -1, 1, 0, 1, 0});
        tbl.push_back('{16, 0, 0, 0,  -1, 1, 1, 0, 16});
        tbl.push_back('{16, 0, 1, 25, -1, 1, 0, 1, 16});
        tbl.push_back('{10, 0, 0, 40, -1, 1, 1, 0, 10});
        tbl.push_back('{5,  0, 0, 0,   2, 1, 0, 0, 1});
        tbl.push_back('{5,  0, 0, 20, -1, 0, 1, 0, 5});
        tbl.push_back('{7,  0, 1, 30, -1, 1, 0, 1, 7});
        tbl.push_back('{1,  0, 0, 0,  -1, 1, 1, 0, 1});
        for (int i = 0; i < 6; i++) begin
            vec_t r;
            r.n          = $urandom_range(1, CAP + 2);
            r.fixed      = 1'b0;
            r.bad        = 1'($urandom_range(0, 1));
            r.gap_pct    = $urandom_range(0, 60);
            r.abort_at   = -1;
            r.pre_reset  = 1'b1;
            r.exp_done   = (r.n <= CAP) && !r.bad;
            r.exp_err    = !r.exp_done;
            r.exp_writes = (r.n <= CAP) ? r.n : 0;
            tbl.push_back(r);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            run_image(tbl[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
